// File: rtl/tran_dir_arbiter.sv
// Direction arbiter for a shared bidirectional pass-switch net.
// Ports: clk/rst (sync, active-high), req_a/req_b in;
//   gnt_a/gnt_b, drv_a2b/drv_b2a, turn, hold_cnt out (all registered).
module tran_dir_arbiter #(
  parameter int unsigned TURN_CYC = 2,
  parameter int unsigned MAX_HOLD = 8,
  parameter int unsigned CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_a,
  input  logic             req_b,
  output logic             gnt_a,
  output logic             gnt_b,
  output logic             drv_a2b,
  output logic             drv_b2a,
  output logic             turn,
  output logic [CNT_W-1:0] hold_cnt
);

  typedef enum logic [1:0] {
    IDLE,
    OWN_A,
    OWN_B,
    TURN
  } state_t;

  localparam logic [CNT_W-1:0] TURN_N  = CNT_W'(TURN_CYC);
  localparam logic [CNT_W-1:0] MAX_N   = CNT_W'(MAX_HOLD);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_TOP = '1;
  localparam logic             HOLD_ON = (MAX_HOLD != 0);

  state_t           state, state_n;
  logic             last_b, last_b_n;
  logic [CNT_W-1:0] turn_cnt, turn_cnt_n;
  logic [CNT_W-1:0] hold_n;
  logic             gnt_a_n, gnt_b_n, turn_n;
  logic             pick_a, pick_b;
  logic             pre_a, pre_b;

  always_comb begin
    state_n    = state;
    last_b_n   = last_b;
    turn_cnt_n = turn_cnt;

    // last_b set means B owned last, so A wins a tie
    pick_a = req_a & (~req_b | last_b);
    pick_b = req_b & (~req_a | ~last_b);

    pre_a = HOLD_ON & req_b & (hold_cnt == MAX_N);
    pre_b = HOLD_ON & req_a & (hold_cnt == MAX_N);

    unique case (state)
      IDLE: begin
        if (pick_a)      state_n = OWN_A;
        else if (pick_b) state_n = OWN_B;
      end
      OWN_A: begin
        if (!req_a || pre_a) begin
          state_n    = TURN;
          last_b_n   = 1'b0;
          turn_cnt_n = TURN_N;
        end
      end
      OWN_B: begin
        if (!req_b || pre_b) begin
          state_n    = TURN;
          last_b_n   = 1'b1;
          turn_cnt_n = TURN_N;
        end
      end
      TURN: begin
        // arbitrate only in the final dead cycle
        if (turn_cnt <= ONE) begin
          if (pick_a)      state_n = OWN_A;
          else if (pick_b) state_n = OWN_B;
          else             state_n = IDLE;
        end else begin
          turn_cnt_n = turn_cnt - ONE;
        end
      end
      default: state_n = IDLE;
    endcase

    gnt_a_n = (state_n == OWN_A);
    gnt_b_n = (state_n == OWN_B);
    turn_n  = (state_n == TURN);

    hold_n = '0;
    if (gnt_a_n || gnt_b_n) begin
      if (state_n != state)        hold_n = ONE;
      else if (hold_cnt != CNT_TOP) hold_n = hold_cnt + ONE;
      else                          hold_n = hold_cnt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      last_b   <= 1'b1;
      turn_cnt <= '0;
      gnt_a    <= 1'b0;
      gnt_b    <= 1'b0;
      drv_a2b  <= 1'b0;
      drv_b2a  <= 1'b0;
      turn     <= 1'b0;
      hold_cnt <= '0;
    end else begin
      state    <= state_n;
      last_b   <= last_b_n;
      turn_cnt <= turn_cnt_n;
      gnt_a    <= gnt_a_n;
      gnt_b    <= gnt_b_n;
      drv_a2b  <= gnt_a_n;
      drv_b2a  <= gnt_b_n;
      turn     <= turn_n;
      hold_cnt <= hold_n;
    end
  end

endmodule

// File: tb/tb_tran_dir_arbiter.sv
// Directed self-checking bench for tran_dir_arbiter
// (TURN_CYC=2, MAX_HOLD=4) plus a random-request invariant run.
module tb_tran_dir_arbiter;

  localparam int TC = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_a = 1'b0;
  logic       req_b = 1'b0;
  logic       gnt_a, gnt_b, drv_a2b, drv_b2a, turn;
  logic [7:0] hold_cnt;

  int n_assert = 0;
  int n_fail   = 0;

  logic prev_any = 1'b0;
  logic seen_fall = 1'b0;
  logic any_g;
  int   low_run = 0;

  tran_dir_arbiter #(
    .TURN_CYC(2),
    .MAX_HOLD(4),
    .CNT_W   (8)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .req_a   (req_a),
    .req_b   (req_b),
    .gnt_a   (gnt_a),
    .gnt_b   (gnt_b),
    .drv_a2b (drv_a2b),
    .drv_b2a (drv_b2a),
    .turn    (turn),
    .hold_cnt(hold_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic ga,
                     input logic gb, input logic t,
                     input logic [7:0] hc);
    logic [12:0] got, exp;
    got = {gnt_a, gnt_b, drv_a2b, drv_b2a, turn, hold_cnt};
    exp = {ga, gb, ga, gb, t, hc};
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  // invariants sampled away from the active edge
  always @(negedge clk) begin
    if (rst) begin
      prev_any  = 1'b0;
      seen_fall = 1'b0;
      low_run   = 0;
    end else begin
      any_g = gnt_a | gnt_b;
      n_assert++;
      assert (!(gnt_a && gnt_b)) else begin
        n_fail++;
        $error("FAIL inv_overlap: got %b%b expected not 11",
               gnt_a, gnt_b);
      end
      n_assert++;
      assert (drv_a2b === gnt_a && drv_b2a === gnt_b) else begin
        n_fail++;
        $error("FAIL inv_drv: got drv %b%b expected %b%b",
               drv_a2b, drv_b2a, gnt_a, gnt_b);
      end
      n_assert++;
      assert (!(turn && any_g)) else begin
        n_fail++;
        $error("FAIL inv_turn: got turn=%b gnt=%b expected no gnt",
               turn, any_g);
      end
      if (any_g && !prev_any && seen_fall) begin
        n_assert++;
        assert (low_run >= TC) else begin
          n_fail++;
          $error("FAIL inv_gap: got %0d idle cycles expected >= %0d",
                 low_run, TC);
        end
      end
      if (!any_g && prev_any) seen_fall = 1'b1;
      low_run  = any_g ? 0 : low_run + 1;
      prev_any = any_g;
    end
  end

  initial begin
    // reset state
    tick();
    chk("rst0", 0, 0, 0, 0);
    tick();
    rst = 1'b0;
    repeat (3) tick();
    chk("idle", 0, 0, 0, 0);

    // 1: single owner then release
    req_a = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      chk("t1_own", 1, 0, 0, 8'(i));
    end
    req_a = 1'b0;
    tick(); chk("t1_turn1", 0, 0, 1, 0);
    tick(); chk("t1_turn2", 0, 0, 1, 0);
    tick(); chk("t1_idle", 0, 0, 0, 0);

    // 2: tie from reset, preempt alternation
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    chk("t2_rst", 0, 0, 0, 0);
    req_a = 1'b1; req_b = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      tick(); chk("t2_a", 1, 0, 0, 8'(i));
    end
    tick(); chk("t2_turn1", 0, 0, 1, 0);
    tick(); chk("t2_turn2", 0, 0, 1, 0);
    for (int i = 1; i <= 4; i++) begin
      tick(); chk("t2_b", 0, 1, 0, 8'(i));
    end
    tick(); chk("t2_turn3", 0, 0, 1, 0);
    tick(); chk("t2_turn4", 0, 0, 1, 0);
    tick(); chk("t2_a_again", 1, 0, 0, 1);
    req_a = 1'b0; req_b = 1'b0;
    tick(); chk("t2_rel1", 0, 0, 1, 0);
    tick(); chk("t2_rel2", 0, 0, 1, 0);
    tick(); chk("t2_idle", 0, 0, 0, 0);

    // 3: lone owner is never preempted
    req_a = 1'b1;
    for (int i = 1; i <= 50; i++) begin
      tick();
      if (i <= 6 || i == 50) chk("t3_own", 1, 0, 0, 8'(i));
    end

    // 4: owner drops as other side raises
    req_a = 1'b0; req_b = 1'b1;
    tick(); chk("t4_turn1", 0, 0, 1, 0);
    tick(); chk("t4_turn2", 0, 0, 1, 0);
    tick(); chk("t4_b", 0, 1, 0, 1);
    tick(); chk("t4_b2", 0, 1, 0, 2);

    // 5: reset in OWN_B, then in TURN with A as last owner
    rst = 1'b1;
    tick(); chk("t5_rst_own", 0, 0, 0, 0);
    rst = 1'b0; req_b = 1'b0; req_a = 1'b1;
    tick(); chk("t5_a", 1, 0, 0, 1);
    req_a = 1'b0;
    tick(); chk("t5_turn", 0, 0, 1, 0);
    rst = 1'b1;
    tick(); chk("t5_rst_turn", 0, 0, 0, 0);
    rst = 1'b0; req_a = 1'b1; req_b = 1'b1;
    tick(); chk("t5_tie_a", 1, 0, 0, 1);

    // 6: release with immediate re-request
    req_b = 1'b0;
    tick(); chk("t6_a2", 1, 0, 0, 2);
    req_a = 1'b0;
    tick(); chk("t6_turn1", 0, 0, 1, 0);
    req_a = 1'b1;
    tick(); chk("t6_turn2", 0, 0, 1, 0);
    tick(); chk("t6_a_back", 1, 0, 0, 1);

    // release coinciding with preempt: single turnaround
    req_b = 1'b1;
    tick(); chk("t7_a2", 1, 0, 0, 2);
    tick(); chk("t7_a3", 1, 0, 0, 3);
    tick(); chk("t7_a4", 1, 0, 0, 4);
    req_a = 1'b0;
    tick(); chk("t7_turn1", 0, 0, 1, 0);
    tick(); chk("t7_turn2", 0, 0, 1, 0);
    tick(); chk("t7_b", 0, 1, 0, 1);

    // random stress; invariants checked on every cycle
    for (int i = 0; i < 10000; i++) begin
      req_a = ($urandom_range(0, 3) != 0) ? req_a : ~req_a;
      req_b = ($urandom_range(0, 3) != 0) ? req_b : ~req_b;
      tick();
    end

    req_a = 1'b0; req_b = 1'b0;
    repeat (5) tick();
    chk("end_idle", 0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
